// File: rtl/adder_unit_if.sv
// Operand/result bundle for adder_unit.
// The master drives the operands and the slave returns the registered sum and flags.
interface adder_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, y, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, y, cout, overflow, zero
    );
endinterface

// File: rtl/adder_unit.sv
// Registered WIDTH-bit adder: y = a + b + cin, with carry-out, signed-overflow and zero flags.
// One-cycle latency, valid-qualified, no back-pressure. Outputs hold while no new operands
// arrive.
// Build option: define ADDER_SAT_EN for unsigned saturation (y forced to all-ones on carry-out).
module adder_unit #(
    parameter int unsigned WIDTH = 8
) (
    input logic        clk,
    input logic        rst_n,
    adder_unit_if.slave bus
);
    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw_y;
    logic [WIDTH-1:0] y_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Next result: full-width sum, flags derived from the raw sum, zero from the final y.
    always_comb begin
        sum    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        raw_y  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        ovf_d  = (bus.a[Msb] == bus.b[Msb]) & (raw_y[Msb] != bus.a[Msb]);
`ifdef ADDER_SAT_EN
        y_d    = cout_d ? {WIDTH{1'b1}} : raw_y;
`else
        y_d    = raw_y;
`endif
        zero_d = (y_d == '0);
    end

    // Output stage: reset clears everything; result registers load only on in_valid so
    // idle-cycle inputs (possibly X) never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_q    <= y_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_adder_unit.sv
// Self-checking bench for adder_unit (WIDTH=8) with a queue-based scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the
// capturing rising edge.
module tb_adder_unit;
    typedef struct packed {
        logic [7:0] y;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];
    exp_t e;

    adder_unit_if #(.WIDTH(8)) bus ();

    adder_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum for y/cout, signed range check for overflow.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t r;
        int   s;
        int   ss;
        s      = int'(a) + int'(b) + int'(cin);
        ss     = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r.cout = (s > 255);
        r.y    = s[7:0];
`ifdef ADDER_SAT_EN
        if (r.cout) r.y = 8'hFF;
`endif
        r.ovf  = (ss > 127) || (ss < -128);
        r.zero = (r.y == 8'h00);
        return r;
    endfunction

    // Present one operand set (call just after a falling edge) and record its expectation.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        exp_q.push_back(model(a, b, cin));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a        = 'x;
        bus.b        = 'x;
        bus.cin      = 1'bx;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 8'h12;
        bus.b        = 8'h34;
        bus.cin      = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.y, bus.cout, bus.overflow, bus.zero} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got y=%h c=%b o=%b z=%b want all 0",
                     bus.y, bus.cout, bus.overflow, bus.zero);
        end
        rst_n = 1'b1;
        idle();
        exp_q.delete();
    endtask

    task automatic test_basic();
        @(negedge clk);
        send(8'd100, 8'd27, 1'b0);
        @(negedge clk);
        idle();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_valid: got %b want 1", bus.out_valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.y, bus.cout, bus.overflow, bus.zero} !== {e.y, e.cout, e.ovf, e.zero}) begin
            n_err++;
            $display("FAIL basic_result: got y=%h c=%b o=%b z=%b want y=%h c=%b o=%b z=%b",
                     bus.y, bus.cout, bus.overflow, bus.zero, e.y, e.cout, e.ovf, e.zero);
        end
        n_cmp++;
        if (bus.y !== 8'd127) begin
            n_err++;
            $display("FAIL basic_literal: got y=%0d want 127", bus.y);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_single_pulse: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want_y;
        logic       want_z;
`ifdef ADDER_SAT_EN
        want_y = 8'hFF;
        want_z = 1'b0;
`else
        want_y = 8'h00;
        want_z = 1'b1;
`endif
        @(negedge clk);
        send(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero}
            !== {1'b1, e.y, e.cout, e.ovf, e.zero}) begin
            n_err++;
            $display("FAIL wrap_result: got v=%b y=%h c=%b o=%b z=%b want v=1 y=%h c=%b o=%b z=%b",
                     bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero,
                     e.y, e.cout, e.ovf, e.zero);
        end
        n_cmp++;
        if ({bus.y, bus.cout, bus.zero} !== {want_y, 1'b1, want_z}) begin
            n_err++;
            $display("FAIL wrap_literal: got y=%h c=%b z=%b want y=%h c=1 z=%b",
                     bus.y, bus.cout, bus.zero, want_y, want_z);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        send(8'h7F, 8'h01, 1'b0);
        @(negedge clk);
        send(8'h80, 8'h80, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero}
            !== {1'b1, e.y, e.cout, e.ovf, e.zero}) begin
            n_err++;
            $display("FAIL ovf_pos: got v=%b y=%h c=%b o=%b z=%b want v=1 y=%h c=%b o=%b z=%b",
                     bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero,
                     e.y, e.cout, e.ovf, e.zero);
        end
        n_cmp++;
        if ({bus.y, bus.overflow, bus.cout} !== {8'h80, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_pos_literal: got y=%h o=%b c=%b want y=80 o=1 c=0",
                     bus.y, bus.overflow, bus.cout);
        end
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero}
            !== {1'b1, e.y, e.cout, e.ovf, e.zero}) begin
            n_err++;
            $display("FAIL ovf_neg: got v=%b y=%h c=%b o=%b z=%b want v=1 y=%h c=%b o=%b z=%b",
                     bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero,
                     e.y, e.cout, e.ovf, e.zero);
        end
        n_cmp++;
        if ({bus.overflow, bus.cout} !== 2'b11) begin
            n_err++;
            $display("FAIL ovf_neg_literal: got o=%b c=%b want o=1 c=1",
                     bus.overflow, bus.cout);
        end
    endtask

    task automatic test_cin_hold();
        @(negedge clk);
        send(8'h0F, 8'h00, 1'b1);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero}
            !== {1'b1, e.y, e.cout, e.ovf, e.zero}) begin
            n_err++;
            $display("FAIL cin_result: got v=%b y=%h c=%b o=%b z=%b want v=1 y=%h c=%b o=%b z=%b",
                     bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero,
                     e.y, e.cout, e.ovf, e.zero);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.out_valid, bus.y} !== {1'b0, 8'h10}) begin
                n_err++;
                $display("FAIL hold_%0d: got v=%b y=%h want v=0 y=10",
                         i, bus.out_valid, bus.y);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 55; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stream_%0d: scoreboard empty", i);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero}
                        !== {1'b1, e.y, e.cout, e.ovf, e.zero}) begin
                        n_err++;
                        $display("FAIL stream_%0d: got v=%b y=%h c=%b o=%b z=%b want v=1 y=%h c=%b o=%b z=%b",
                                 i, bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero,
                                 e.y, e.cout, e.ovf, e.zero);
                    end
                end
            end
            send(8'($urandom), 8'($urandom), 1'($urandom));
        end
        // Reset mid-stream with in_valid still high: the in-flight result is discarded.
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero} !== 12'h000) begin
            n_err++;
            $display("FAIL stream_reset: got v=%b y=%h c=%b o=%b z=%b want all 0",
                     bus.out_valid, bus.y, bus.cout, bus.overflow, bus.zero);
        end
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_post_reset: got valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
        bus.cin      = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_cin_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
